// File: rtl/intersection_scheduler_pkg.sv
// Shared types for the intersection scheduler: phases, light codes and
// the per-approach light bundle.
package traffic_pkg;

  typedef enum logic [2:0] {
    STARTUP,
    ALL_RED,
    GREEN,
    YELLOW,
    FLASH
  } phase_e;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_OFF    = 3'b000;

  typedef logic [3:0][2:0] lights_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // All approaches red except the one at idx, which shows lt.
  function automatic lights_t one_lit(logic [1:0] idx, logic [2:0] lt);
    lights_t l;
    l      = {4{LT_RED}};
    l[idx] = lt;
    return l;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request inputs and light/grant outputs of one intersection.
interface intersection_scheduler_if;
  import traffic_pkg::*;

  logic [3:0] requests;
  logic [3:0] preferentials;
  logic [3:0] force_reds;
  logic       attention;
  lights_t    lights;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [2:0] phase;

  modport master (
    output requests, preferentials, force_reds, attention,
    input  lights, grant_valid, grant_idx, phase
  );

  modport slave (
    input  requests, preferentials, force_reds, attention,
    output lights, grant_valid, grant_idx, phase
  );

endinterface

// File: rtl/intersection_scheduler_rr_picker.sv
// Round-robin first-set finder over four requests, starting at ptr.
module rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  // Scan farthest-first so the closest set bit to ptr wins.
  always_comb begin
    valid = |req;
    idx   = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) idx = ptr + 2'(i);
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Four-approach traffic light sequencer: startup, all-red clearance,
// round-robin green grants with priority, yellow and attention flashing.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int STARTUP_STEP = 8,
  parameter int ALL_RED_TIME = 2,
  parameter int GREEN_MIN    = 4,
  parameter int GREEN_MAX    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int FLASH_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  intersection_scheduler_if.slave bus
);

  localparam int TMAX = max2(
    max2(max2(STARTUP_STEP, ALL_RED_TIME), max2(GREEN_MIN, GREEN_MAX)),
    max2(YELLOW_TIME, FLASH_PERIOD));
  localparam int TW = $clog2(TMAX) + 1;

  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t T_STEP = tmr_t'(STARTUP_STEP - 1);
  localparam tmr_t T_AR   = tmr_t'(ALL_RED_TIME - 1);
  localparam tmr_t T_GMIN = tmr_t'(GREEN_MIN - 1);
  localparam tmr_t T_GMAX = tmr_t'(GREEN_MAX - 1);
  localparam tmr_t T_Y    = tmr_t'(YELLOW_TIME - 1);
  localparam tmr_t T_FP   = tmr_t'(FLASH_PERIOD - 1);

  phase_e     phase_q;
  lights_t    lights_q;
  logic       gv_q;
  logic [1:0] gidx_q;
  logic [1:0] rr_q;
  tmr_t       timer_q;

  logic [3:0] elig;
  logic [3:0] pelig;
  logic [3:0] others;
  logic       pv;
  logic       ev;
  logic [1:0] pidx;
  logic [1:0] eidx;
  logic [1:0] pick;
  logic       min_ok;
  logic       g_exit;
  tmr_t       t_inc;

  assign elig   = bus.requests & ~bus.force_reds;
  assign pelig  = bus.preferentials & ~bus.force_reds;
  assign others = (elig | pelig) & ~(4'b0001 << gidx_q);
  assign pick   = pv ? pidx : eidx;
  assign min_ok = timer_q >= T_GMIN;
  assign t_inc  = (&timer_q) ? timer_q : timer_q + 1'b1;

  assign g_exit = bus.force_reds[gidx_q]
               || (bus.attention && min_ok)
               || (timer_q == T_GMAX)
               || (min_ok && (!bus.requests[gidx_q] || (|others)));

  rr_picker u_pick_pref (
    .req   (pelig),
    .ptr   (rr_q),
    .valid (pv),
    .idx   (pidx)
  );

  rr_picker u_pick_req (
    .req   (elig),
    .ptr   (rr_q),
    .valid (ev),
    .idx   (eidx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= STARTUP;
      lights_q <= '0;
      gv_q     <= 1'b0;
      gidx_q   <= 2'd0;
      rr_q     <= 2'd0;
      timer_q  <= '0;
    end else begin
      unique case (phase_q)
        STARTUP: begin
          if (lights_q[3] == LT_RED) begin
            phase_q <= ALL_RED;
            timer_q <= '0;
          end else if (lights_q[0] == LT_OFF) begin
            lights_q[0] <= LT_RED;
            timer_q     <= '0;
          end else if (timer_q == T_STEP) begin
            timer_q <= '0;
            if (lights_q[1] == LT_OFF)      lights_q[1] <= LT_RED;
            else if (lights_q[2] == LT_OFF) lights_q[2] <= LT_RED;
            else                            lights_q[3] <= LT_RED;
          end else begin
            timer_q <= t_inc;
          end
        end
        ALL_RED: begin
          if (timer_q >= T_AR && bus.attention) begin
            phase_q  <= FLASH;
            lights_q <= {4{LT_YELLOW}};
            timer_q  <= '0;
          end else if (timer_q >= T_AR && (pv || ev)) begin
            phase_q  <= GREEN;
            lights_q <= one_lit(pick, LT_GREEN);
            gv_q     <= 1'b1;
            gidx_q   <= pick;
            timer_q  <= '0;
          end else begin
            lights_q <= {4{LT_RED}};
            timer_q  <= t_inc;
          end
        end
        GREEN: begin
          if (g_exit) begin
            phase_q  <= YELLOW;
            lights_q <= one_lit(gidx_q, LT_YELLOW);
            timer_q  <= '0;
          end else begin
            timer_q <= t_inc;
          end
        end
        YELLOW: begin
          if (timer_q >= T_Y) begin
            phase_q  <= ALL_RED;
            lights_q <= {4{LT_RED}};
            gv_q     <= 1'b0;
            rr_q     <= gidx_q + 2'd1;
            timer_q  <= '0;
          end else begin
            timer_q <= t_inc;
          end
        end
        FLASH: begin
          if (!bus.attention) begin
            phase_q  <= ALL_RED;
            lights_q <= {4{LT_RED}};
            timer_q  <= '0;
          end else if (timer_q >= T_FP) begin
            lights_q <= (lights_q[0] == LT_YELLOW) ? '0 : {4{LT_YELLOW}};
            timer_q  <= '0;
          end else begin
            timer_q <= t_inc;
          end
        end
        default: begin
          phase_q  <= STARTUP;
          lights_q <= '0;
          gv_q     <= 1'b0;
          timer_q  <= '0;
        end
      endcase
    end
  end

  assign bus.lights      = lights_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_idx   = gidx_q;
  assign bus.phase       = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: per-cycle vector table feeding a
// scoreboard queue, plus an asynchronous mid-green reset sequence.
module tb_intersection_scheduler;
  import traffic_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  typedef struct {
    logic [3:0] req;
    logic [3:0] pref;
    logic [3:0] frc;
    logic       att;
    int         n;
    lights_t    lt;
    logic       gv;
    logic [1:0] gi;
    phase_e     ph;
  } vec_t;

  typedef struct {
    int         id;
    lights_t    lt;
    logic       gv;
    logic [1:0] gi;
    phase_e     ph;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t mon_e;

  intersection_scheduler_if bus ();

  intersection_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lights_t lr(int g, logic [2:0] c);
    lights_t x;
    for (int k = 0; k < 4; k++) x[k] = (k == g) ? c : R;
    return x;
  endfunction

  function automatic vec_t v(logic [3:0] rq, logic [3:0] pf,
                             logic [3:0] fr, logic at, int n,
                             lights_t lt, logic gv, logic [1:0] gi,
                             phase_e ph);
    vec_t r;
    r.req = rq; r.pref = pf; r.frc = fr; r.att = at; r.n = n;
    r.lt = lt; r.gv = gv; r.gi = gi; r.ph = ph;
    return r;
  endfunction

  task automatic chk(string nm, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (bus.lights !== mon_e.lt || bus.grant_valid !== mon_e.gv ||
          bus.grant_idx !== mon_e.gi || bus.phase !== 3'(mon_e.ph)) begin
        n_errors++;
        $display("FAIL vec%0d: got lights=%h gv=%b idx=%0d phase=%0d, want lights=%h gv=%b idx=%0d phase=%0d",
                 mon_e.id, bus.lights, bus.grant_valid, bus.grant_idx,
                 bus.phase, mon_e.lt, mon_e.gv, mon_e.gi, 3'(mon_e.ph));
      end
    end
  end

  initial begin
    lights_t allr;
    lights_t ally;
    exp_t    e;
    n_checks = 0;
    n_errors = 0;
    allr = {R, R, R, R};
    ally = {Y, Y, Y, Y};

    // startup ramp; attention is ignored here
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b1, 8, {O, O, O, R}, 0, 0, STARTUP));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 8, {O, O, R, R}, 0, 0, STARTUP));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 8, {O, R, R, R}, 0, 0, STARTUP));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 1, allr, 0, 0, STARTUP));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 3, allr, 0, 0, ALL_RED));
    // single demand on approach 0, dropped at the 4th green cycle
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b0, 4, lr(0, G), 1, 0, GREEN));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 2, lr(0, Y), 1, 0, YELLOW));
    tbl.push_back(v(4'h0, 4'h0, 4'h0, 1'b0, 1, allr, 0, 0, ALL_RED));
    // round robin from rr_ptr=1
    tbl.push_back(v(4'hF, 4'h0, 4'h0, 1'b0, 1, allr, 0, 0, ALL_RED));
    for (int k = 1; k < 4; k++) begin
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 1'b0, 4, lr(k, G), 1, 2'(k), GREEN));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 1'b0, 2, lr(k, Y), 1, 2'(k), YELLOW));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 1'b0, 2, allr, 0, 2'(k), ALL_RED));
    end
    // preferential on 3 jumps ahead of 1
    tbl.push_back(v(4'hF, 4'h0, 4'h0, 1'b0, 1, lr(0, G), 1, 0, GREEN));
    tbl.push_back(v(4'h3, 4'h8, 4'h0, 1'b0, 3, lr(0, G), 1, 0, GREEN));
    tbl.push_back(v(4'h3, 4'h8, 4'h0, 1'b0, 2, lr(0, Y), 1, 0, YELLOW));
    tbl.push_back(v(4'h3, 4'h8, 4'h0, 1'b0, 2, allr, 0, 0, ALL_RED));
    tbl.push_back(v(4'h3, 4'h8, 4'h0, 1'b0, 4, lr(3, G), 1, 3, GREEN));
    tbl.push_back(v(4'h4, 4'h0, 4'h0, 1'b0, 2, lr(3, Y), 1, 3, YELLOW));
    tbl.push_back(v(4'h4, 4'h0, 4'h0, 1'b0, 2, allr, 0, 3, ALL_RED));
    // force red on 2 at timer=1; forced approach never re-granted
    tbl.push_back(v(4'h4, 4'h0, 4'h0, 1'b0, 2, lr(2, G), 1, 2, GREEN));
    tbl.push_back(v(4'h4, 4'h0, 4'h4, 1'b0, 1, lr(2, Y), 1, 2, YELLOW));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 1, lr(2, Y), 1, 2, YELLOW));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 2, allr, 0, 2, ALL_RED));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 8, lr(0, G), 1, 0, GREEN));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 2, lr(0, Y), 1, 0, YELLOW));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 2, allr, 0, 0, ALL_RED));
    tbl.push_back(v(4'h5, 4'h4, 4'h4, 1'b0, 1, lr(0, G), 1, 0, GREEN));
    // attention mid-green, flashing, then resume
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 3, lr(0, G), 1, 0, GREEN));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 2, lr(0, Y), 1, 0, YELLOW));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 2, allr, 0, 0, ALL_RED));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 4, ally, 0, 0, FLASH));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 4, '0, 0, 0, FLASH));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b1, 4, ally, 0, 0, FLASH));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b0, 2, allr, 0, 0, ALL_RED));
    tbl.push_back(v(4'h1, 4'h0, 4'h0, 1'b0, 1, lr(0, G), 1, 0, GREEN));

    rst = 1'b0;
    bus.requests      = '0;
    bus.preferentials = '0;
    bus.force_reds    = '0;
    bus.attention     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_lights", int'(bus.lights), 0);
    chk("rst_gv", int'(bus.grant_valid), 0);
    chk("rst_phase", int'(bus.phase), int'(STARTUP));

    rst = 1'b1;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        bus.requests      = tbl[i].req;
        bus.preferentials = tbl[i].pref;
        bus.force_reds    = tbl[i].frc;
        bus.attention     = tbl[i].att;
        e.id = i; e.lt = tbl[i].lt; e.gv = tbl[i].gv;
        e.gi = tbl[i].gi; e.ph = tbl[i].ph;
        sb.push_back(e);
        @(negedge clk);
      end
    end
    chk("sb_drained", sb.size(), 0);

    // asynchronous reset while green, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("async_lights", int'(bus.lights), 0);
    chk("async_gv", int'(bus.grant_valid), 0);
    chk("async_idx", int'(bus.grant_idx), 0);
    chk("async_phase", int'(bus.phase), int'(STARTUP));

    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
